// File: rtl/pll_reset_ctrl.sv
// Reset sequencer for a refclk-referenced PLL: pulses pll_rst, waits for a stable
// synchronized lock, retries on timeout, and parks the PLL in FAULT after repeated failures.
module pll_reset_ctrl #(
  parameter int RST_CYCLES          = 50,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             force_reset,
  output logic             pll_rst,
  output logic             clk_ready,
  output logic             fault,
  output logic [CNT_W-1:0] relock_count,
  output logic [2:0]       state_o
);

  localparam int MAX_A   = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int RW      = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_ASSERT_RST = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABILIZE  = 3'd2,
    ST_READY      = 3'd3,
    ST_FAULT      = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [CNT_W-1:0]  relock_q, relock_d;
  logic [1:0]        sync_q;
  logic              locked_s;
  logic              restart;
  logic              pll_rst_q, clk_ready_q, fault_q;

  // pll_locked is asynchronous to refclk; only the second flop is ever looked at.
  assign locked_s = sync_q[1];

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    relock_d = relock_q;
    restart  = 1'b0;
    unique case (state_q)
      ST_ASSERT_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A lock seen on the timeout cycle still wins over the retry.
        if (locked_s) begin
          state_d = ST_STABILIZE;
        end else if (cnt_q == TO_LAST) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == RETRY_LIMIT) ? ST_FAULT : ST_ASSERT_RST;
        end
      end
      ST_STABILIZE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_READY;
          retry_d = '0;
        end
      end
      ST_READY: begin
        if (!locked_s) begin
          state_d = ST_ASSERT_RST;
          if (relock_q != '1) relock_d = relock_q + 1'b1;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: state_d = ST_ASSERT_RST;
    endcase

    // force_reset is a single-cycle request honoured in any state; it beats every
    // other transition but leaves the relock history alone.
    if (force_reset) begin
      state_d  = ST_ASSERT_RST;
      retry_d  = '0;
      relock_d = relock_q;
      restart  = 1'b1;
    end

    if (restart || (state_d != state_q)) cnt_d = '0;
    else if (cnt_q != '1)                cnt_d = cnt_q + 1'b1;
    else                                 cnt_d = cnt_q;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= ST_ASSERT_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      relock_q    <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      sync_q      <= {sync_q[0], pll_locked};
      pll_rst_q   <= (state_d == ST_ASSERT_RST) || (state_d == ST_FAULT);
      clk_ready_q <= (state_d == ST_READY);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign pll_rst      = pll_rst_q;
  assign clk_ready    = clk_ready_q;
  assign fault        = fault_q;
  assign relock_count = relock_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl: stimulus pushes the expected output tuple and the
// cycle it must appear in; a negedge monitor pops and compares on every output change.
module tb_pll_reset_ctrl;

  localparam int EW = 42;  // {cycle[31:0], state[2:0], pll_rst, clk_ready, fault, relock[3:0]}

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       force_reset;
  logic       pll_rst;
  logic       clk_ready;
  logic       fault;
  logic [3:0] relock_count;
  logic [2:0] state_o;

  pll_reset_ctrl #(
    .RST_CYCLES          (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES         (3),
    .CNT_W               (4)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .force_reset  (force_reset),
    .pll_rst      (pll_rst),
    .clk_ready    (clk_ready),
    .fault        (fault),
    .relock_count (relock_count),
    .state_o      (state_o)
  );

  // clock / reset block
  int cyc = 0;
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] ent;
  logic [9:0]    cur;
  logic [9:0]    prev = 'x;
  logic          mon_en = 1'b0;
  int            total = 0;
  int            bad = 0;
  int            exp_rc = 0;

  task automatic push(input int t, input logic [2:0] st, input logic pr, input logic cr,
                      input logic f, input int rc);
    exp_q.push_back({32'(t), st, pr, cr, f, 4'(rc)});
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  always @(negedge refclk) begin
    if (mon_en) begin
      cur = {state_o, pll_rst, clk_ready, fault, relock_count};
      while (exp_q.size() > 0 && exp_q[0][EW-1:10] < 32'(cyc)) begin
        ent = exp_q.pop_front();
        total++;
        bad++;
        $display("FAIL missed_change: cycle=%0d got st=%0d rst=%b rdy=%b flt=%b rc=%0d exp at cycle %0d st=%0d rst=%b rdy=%b flt=%b rc=%0d",
                 cyc, cur[9:7], cur[6], cur[5], cur[4], cur[3:0],
                 ent[EW-1:10], ent[9:7], ent[6], ent[5], ent[4], ent[3:0]);
      end
      if (cur !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: cycle=%0d got st=%0d rst=%b rdy=%b flt=%b rc=%0d exp no change",
                   cyc, cur[9:7], cur[6], cur[5], cur[4], cur[3:0]);
        end else begin
          ent = exp_q.pop_front();
          if (ent[EW-1:10] != 32'(cyc) || ent[9:0] !== cur) begin
            bad++;
            $display("FAIL out_change: cycle=%0d got st=%0d rst=%b rdy=%b flt=%b rc=%0d exp cycle=%0d st=%0d rst=%b rdy=%b flt=%b rc=%0d",
                     cyc, cur[9:7], cur[6], cur[5], cur[4], cur[3:0],
                     ent[EW-1:10], ent[9:7], ent[6], ent[5], ent[4], ent[3:0]);
          end
        end
        prev = cur;
      end
    end
  end

  // driver
  int c;
  initial begin
    rst         = 1'b1;
    pll_locked  = 1'b1;
    force_reset = 1'b0;

    // power-up with lock present from the start
    tick_to(1);
    push(1, 3'd0, 1'b1, 1'b0, 1'b0, 0);
    mon_en = 1'b1;
    tick_to(3);
    rst = 1'b0;
    c = cyc;
    push(c + 4,  3'd1, 1'b0, 1'b0, 1'b0, 0);
    push(c + 5,  3'd2, 1'b0, 1'b0, 1'b0, 0);
    push(c + 13, 3'd3, 1'b0, 1'b1, 1'b0, 0);
    tick_to(c + 17);

    // lock loss in READY for 3 cycles
    c = cyc;
    pll_locked = 1'b0;
    exp_rc = 1;
    push(c + 3,  3'd0, 1'b1, 1'b0, 1'b0, exp_rc);
    push(c + 7,  3'd1, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 8,  3'd2, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 16, 3'd3, 1'b0, 1'b1, 1'b0, exp_rc);
    tick_to(c + 3);
    pll_locked = 1'b1;
    tick_to(c + 20);

    // unstable lock: loss seen on the 5th STABILIZE cycle
    c = cyc;
    force_reset = 1'b1;
    push(c + 1,  3'd0, 1'b1, 1'b0, 1'b0, exp_rc);
    push(c + 5,  3'd1, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 6,  3'd2, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 11, 3'd1, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 12, 3'd2, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 20, 3'd3, 1'b0, 1'b1, 1'b0, exp_rc);
    tick_to(c + 1);
    force_reset = 1'b0;
    tick_to(c + 8);
    pll_locked = 1'b0;
    tick_to(c + 9);
    pll_locked = 1'b1;
    tick_to(c + 24);

    // loss coincides with the last STABILIZE count: back to WAIT_LOCK, not READY
    c = cyc;
    force_reset = 1'b1;
    push(c + 1,  3'd0, 1'b1, 1'b0, 1'b0, exp_rc);
    push(c + 5,  3'd1, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 6,  3'd2, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 14, 3'd1, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 15, 3'd2, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 23, 3'd3, 1'b0, 1'b1, 1'b0, exp_rc);
    tick_to(c + 1);
    force_reset = 1'b0;
    tick_to(c + 11);
    pll_locked = 1'b0;
    tick_to(c + 12);
    pll_locked = 1'b1;
    tick_to(c + 26);

    // lock stuck low: three timeouts then FAULT
    c = cyc;
    pll_locked  = 1'b0;
    force_reset = 1'b1;
    push(c + 1,   3'd0, 1'b1, 1'b0, 1'b0, exp_rc);
    push(c + 5,   3'd1, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 37,  3'd0, 1'b1, 1'b0, 1'b0, exp_rc);
    push(c + 41,  3'd1, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 73,  3'd0, 1'b1, 1'b0, 1'b0, exp_rc);
    push(c + 77,  3'd1, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 109, 3'd4, 1'b1, 1'b0, 1'b1, exp_rc);
    tick_to(c + 1);
    force_reset = 1'b0;
    tick_to(c + 115);

    // force_reset out of FAULT; later a lock rise on the timeout cycle wins
    c = cyc;
    force_reset = 1'b1;
    push(c + 1,  3'd0, 1'b1, 1'b0, 1'b0, exp_rc);
    push(c + 5,  3'd1, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 37, 3'd0, 1'b1, 1'b0, 1'b0, exp_rc);
    push(c + 41, 3'd1, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 73, 3'd2, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 81, 3'd3, 1'b0, 1'b1, 1'b0, exp_rc);
    tick_to(c + 1);
    force_reset = 1'b0;
    tick_to(c + 70);
    pll_locked = 1'b1;
    tick_to(c + 85);

    // 20 lock-loss events: relock_count saturates at 15
    for (int i = 0; i < 20; i++) begin
      c = cyc;
      pll_locked = 1'b0;
      exp_rc = (exp_rc < 15) ? exp_rc + 1 : 15;
      push(c + 3,  3'd0, 1'b1, 1'b0, 1'b0, exp_rc);
      push(c + 7,  3'd1, 1'b0, 1'b0, 1'b0, exp_rc);
      push(c + 8,  3'd2, 1'b0, 1'b0, 1'b0, exp_rc);
      push(c + 16, 3'd3, 1'b0, 1'b1, 1'b0, exp_rc);
      tick_to(c + 3);
      pll_locked = 1'b1;
      tick_to(c + 20);
    end

    // rst during STABILIZE, held together with force_reset
    c = cyc;
    force_reset = 1'b1;
    push(c + 1, 3'd0, 1'b1, 1'b0, 1'b0, exp_rc);
    push(c + 5, 3'd1, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 6, 3'd2, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 9, 3'd0, 1'b1, 1'b0, 1'b0, 0);
    tick_to(c + 1);
    force_reset = 1'b0;
    tick_to(c + 8);
    rst         = 1'b1;
    force_reset = 1'b1;
    tick_to(c + 10);
    rst         = 1'b0;
    force_reset = 1'b0;
    c = cyc;
    exp_rc = 0;
    push(c + 4,  3'd1, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 5,  3'd2, 1'b0, 1'b0, 1'b0, exp_rc);
    push(c + 13, 3'd3, 1'b0, 1'b1, 1'b0, exp_rc);
    tick_to(c + 20);

    // final report
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expect: got %0d pending entries exp 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_ctrl.md
Name: pll_reset_ctrl

Overview:
- Reset sequencer for the 50 MHz-referenced PLL wrappers, e.g. the 165 MHz clock generator.
- Runs on the always-on reference clock and drives the PLL reset input. Monitors the PLL lock output and raises clk_ready only after lock has stayed stable.
- Re-resets the PLL on lock loss or lock timeout, counts relock events, and declares a fault after repeated failed lock attempts.

Parameters:
- RST_CYCLES, 50: refclk cycles pll_rst is held high per reset attempt (1 us at 50 MHz); must be >= 1.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before clk_ready rises; must be >= 1.
- LOCK_TIMEOUT_CYCLES, 500000: cycles allowed in WAIT_LOCK before a retry (10 ms).
- MAX_RETRIES, 3: consecutive lock timeouts before entering FAULT; must be >= 1.
- CNT_W, 8: width of relock_count.

Ports:
- refclk  input  1  reference clock (50 MHz, free-running); all logic is on its rising edge.
- rst  input  1  synchronous active-high reset.
- pll_locked  input  1  PLL lock indicator; asynchronous to refclk.
- force_reset  input  1  single-cycle request to restart the sequence from ASSERT_RST; valid in any state.
- pll_rst  output  1  reset to the PLL, active-high, registered.
- clk_ready  output  1  PLL output clock is usable, registered.
- fault  output  1  lock could not be obtained after MAX_RETRIES attempts, registered.
- relock_count  output  CNT_W  number of READY->lock-loss events; saturates at all-ones.
- state_o  output  3  current state encoding for debug: 0 ASSERT_RST, 1 WAIT_LOCK, 2 STABILIZE, 3 READY, 4 FAULT.

Behaviour:
- One clock and a synchronous active-high reset; the clock and reset ports are refclk and rst.
- Reset values, applied while rst=1:
  - state=ASSERT_RST, pll_rst=1, clk_ready=0, fault=0, relock_count=0.
  - Synchronizer flops=0; all internal counters=0; retry count=0.
- locked_s is pll_locked passed through a 2-flop synchronizer (2 cycles latency). All decisions use locked_s only.
- One shared cycle counter is used by every state and clears on every state transition.
- All outputs are registered and reflect the state held during the current cycle.
- ASSERT_RST:
  - pll_rst=1 and clk_ready=0.
  - Counts RST_CYCLES cycles in this state, then moves to WAIT_LOCK.
  - With cycle 1 as the first cycle after rst falls, pll_rst is high in cycles 1..RST_CYCLES and low from cycle RST_CYCLES+1.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1, go to STABILIZE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT_CYCLES, increment the retry count. If it now equals MAX_RETRIES, go to FAULT; else go to ASSERT_RST.
- STABILIZE:
  - If locked_s=0, go to WAIT_LOCK; the timeout counter restarts and the retry count is unchanged.
  - After LOCK_STABLE_CYCLES consecutive cycles with locked_s=1, go to READY and clear the retry count.
- READY:
  - clk_ready=1.
  - If locked_s=0, go to ASSERT_RST, increment relock_count (saturating, no wrap), and drop clk_ready to 0 in that same cycle, i.e. on the first cycle spent back in ASSERT_RST.
- FAULT:
  - fault=1, pll_rst=1 (PLL is parked in reset), clk_ready=0.
  - Left only by rst or force_reset.
- force_reset=1 in any state:
  - Next state is ASSERT_RST and the retry count is cleared.
  - fault clears; relock_count is preserved; this overrides every other transition in that cycle.
- Simultaneous events:
  - rst overrides force_reset.
  - A locked_s fall in the same cycle as the STABILIZE count completing gives WAIT_LOCK, not READY.
  - A locked_s rise in the same cycle as the WAIT_LOCK timeout gives STABILIZE (lock wins).
- pll_locked glitches shorter than 1 cycle may be missed; this is acceptable. Any locked_s low cycle in STABILIZE or READY counts as loss.

Test Plan (RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=3, CNT_W=4):
- Power-up with pll_locked held 1 from start:
  - Release rst at cycle 0 -> pll_rst high in cycles 1-4, low from cycle 5.
  - clk_ready rises after 8 cycles in STABILIZE with locked_s=1; state_o sequence is 0,1,2,3.
- Lock loss in READY:
  - Drop pll_locked for 3 cycles -> clk_ready falls 2-3 cycles later and relock_count=1.
  - pll_rst pulses for 4 cycles; after relock, clk_ready returns.
- Unstable lock:
  - Toggle pll_locked low on the 5th STABILIZE cycle -> state returns to 1 and clk_ready stays 0.
  - After a clean 8-cycle stretch, state reaches 3.
- pll_locked stuck 0:
  - Expect 3 timeouts of 32 cycles, each followed by a 4-cycle pll_rst pulse.
  - After the third timeout: fault=1, pll_rst=1, state_o=4.
  - A force_reset pulse then gives fault=0 and a restart at ASSERT_RST.
- Saturation: force 20 lock-loss events -> relock_count stays at 15.
- Reset mid-sequence:
  - Assert rst during STABILIZE -> next cycle state_o=0, pll_rst=1, clk_ready=0, relock_count=0.
  - rst held together with force_reset -> reset values apply.
